pwm_capture_core: RTL

MMIO slot core that measures incoming PWM signals: per channel it reports high time and period in prescaled tick units. It is the receive-side counterpart of the team's PWM generator core and shares its slot bus and divisor/tick scheme, so software can loop generator outputs back and verify duty/frequency. It sits on the MMIO bus; its `pwm_in` pins connect to external or looped-back PWM lines.

---
 rtl/pwm_cap_pkg.sv | 17 +
 rtl/pwm_capture_chan.sv | 120 ++++++++++++
 rtl/pwm_capture_core.sv | 109 ++++++++++
 3 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared types and register addresses for the PWM capture slot core.
package pwm_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } cap_state_t;

  localparam logic [4:0] ADDR_DVSR     = 5'h00;
  localparam logic [4:0] ADDR_CTRL     = 5'h01;
  localparam logic [4:0] ADDR_STAT     = 5'h02;
  localparam logic [4:0] ADDR_CLR      = 5'h03;
  localparam logic [4:0] ADDR_RES_BASE = 5'h10;

endpackage

// File: rtl/pwm_capture_chan.sv
// One capture channel: input synchronizer, edge detect, measurement FSM and
// published high/period result pair.
module pwm_capture_chan
  import pwm_cap_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_pwm,
  input  logic          i_tick,
  input  logic          i_en,
  output logic          o_cap_pulse,
  output logic          o_ovf_pulse,
  output logic [CW-1:0] o_high,
  output logic [CW-1:0] o_period
);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_dly;
  logic          w_rise;
  logic          w_fall;
  cap_state_t    r_state;
  cap_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_at_max;
  logic [CW-1:0] r_hi_sh;
  logic [CW-1:0] w_hi_sh_next;
  logic [CW-1:0] r_high;
  logic [CW-1:0] r_period;

  assign w_rise    = r_sync2 & ~r_dly;
  assign w_fall    = ~r_sync2 & r_dly;
  assign w_cnt_inc = r_cnt + CW'(i_tick);
  assign w_at_max  = (r_cnt == {CW{1'b1}}) && i_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_dly    <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi_sh  <= '0;
      r_high   <= '0;
      r_period <= '0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi_sh <= w_hi_sh_next;
      // High and period load on the same edge so software never sees a torn pair.
      if (o_cap_pulse) begin
        r_high   <= r_hi_sh;
        r_period <= w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_sh_next = r_hi_sh;
    o_cap_pulse  = 1'b0;
    o_ovf_pulse  = 1'b0;
    if (!i_en) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = ARM;
          w_cnt_next   = '0;
        end
        ARM: begin
          if (w_rise) begin
            w_cnt_next   = '0;
            w_state_next = HIGH;
          end
        end
        HIGH: begin
          w_cnt_next = w_cnt_inc;
          if (w_fall) begin
            w_hi_sh_next = w_cnt_inc;
            w_state_next = LOW;
          end else if (w_at_max) begin
            o_ovf_pulse  = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ARM;
          end
        end
        LOW: begin
          w_cnt_next = w_cnt_inc;
          if (w_rise) begin
            o_cap_pulse  = 1'b1;
            w_cnt_next   = '0;
            w_state_next = HIGH;
          end else if (w_at_max) begin
            o_ovf_pulse  = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ARM;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign o_high   = r_high;
  assign o_period = r_period;

endmodule

// File: rtl/pwm_capture_core.sv
// PWM capture MMIO slot: shared tick prescaler, per-channel capture units,
// sticky valid/overflow flags with write-1-to-clear, and the read mux.
module pwm_capture_core
  import pwm_cap_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] pwm_in
);

  logic [31:0]   r_dvsr;
  logic [31:0]   r_q;
  logic          w_tick;
  logic [W-1:0]  r_ctrl;
  logic [W-1:0]  r_valid;
  logic [W-1:0]  r_ovf;
  logic [W-1:0]  w_cap;
  logic [W-1:0]  w_ovf;
  logic [W-1:0]  w_clr_valid;
  logic [W-1:0]  w_clr_ovf;
  logic          w_wr;
  logic [CW-1:0] w_high   [W];
  logic [CW-1:0] w_period [W];
  logic [31:0]   w_res_high   [8];
  logic [31:0]   w_res_period [8];
  logic          w_unused_read;

  // Reads have no side effects, so the strobe is not needed.
  assign w_unused_read = read;

  assign w_wr        = cs && write;
  assign w_tick      = (r_q == 32'd0);
  assign w_clr_valid = (w_wr && addr == ADDR_CLR) ? wr_data[W-1:0]   : '0;
  assign w_clr_ovf   = (w_wr && addr == ADDR_CLR) ? wr_data[W+7:8]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvsr  <= '0;
      r_q     <= '0;
      r_ctrl  <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_wr && addr == ADDR_DVSR) r_dvsr <= wr_data;
      if (w_wr && addr == ADDR_CTRL) r_ctrl <= wr_data[W-1:0];
      // >= rather than == so lowering dvsr below the running count still wraps.
      r_q     <= (r_q >= r_dvsr) ? 32'd0 : r_q + 32'd1;
      r_valid <= (r_valid & ~w_clr_valid) | w_cap;
      r_ovf   <= (r_ovf & ~w_clr_ovf) | w_ovf;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_chan
      pwm_capture_chan #(
        .CW(CW)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .i_pwm      (pwm_in[gi]),
        .i_tick     (w_tick),
        .i_en       (r_ctrl[gi]),
        .o_cap_pulse(w_cap[gi]),
        .o_ovf_pulse(w_ovf[gi]),
        .o_high     (w_high[gi]),
        .o_period   (w_period[gi])
      );
    end

    // Pad results to the full 8-slot window so unused slots read as zero.
    for (gi = 0; gi < 8; gi++) begin : g_res
      if (gi < W) begin : g_used
        assign w_res_high[gi]   = 32'(w_high[gi]);
        assign w_res_period[gi] = 32'(w_period[gi]);
      end else begin : g_empty
        assign w_res_high[gi]   = '0;
        assign w_res_period[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_DVSR: rd_data = r_dvsr;
      ADDR_CTRL: rd_data[W-1:0] = r_ctrl;
      ADDR_STAT: begin
        rd_data[W-1:0] = r_valid;
        rd_data[W+7:8] = r_ovf;
      end
      default: begin
        if (addr[4]) begin
          rd_data = addr[0] ? w_res_period[addr[3:1]] : w_res_high[addr[3:1]];
        end
      end
    endcase
  end

endmodule
